// File: rtl/instr_pkg.sv
// Shared instruction constants, RISC-V base opcodes and the immediate decoder.
// Latency: none, declarations and a pure function only.
// Backpressure: not applicable.
package instr_pkg;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  // Sign-extended immediate selected by the instruction format implied by the opcode
  function automatic logic [31:0] imm_decode(input logic [31:0] i);
    logic [31:0] imm;
    imm = '0;
    case (i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{i[31]}}, i[31:20]};
      OP_STORE:                 imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {i[31:12], 12'b0};
      OP_JAL:                   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits a 32-bit instruction into decode fields, substituting NOP when not valid (imm_out with IMM_GEN_EN).
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module instr_field_split
  import instr_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic [31:0] instr,
  input  logic        valid,
  output logic [6:0]  opcode_out,
  output logic [4:0]  rd_addr_out,
  output logic [2:0]  func3_out,
  output logic [4:0]  rs1_addr_out,
  output logic [4:0]  rs2_addr_out,
  output logic [6:0]  func7_out,
  output logic [24:0] instr_31_7_out
`ifdef IMM_GEN_EN
  ,
  output logic [31:0] imm_out
`endif
);

  logic [31:0] word;

  // An invalid head decodes as the canonical NOP so decode never sees stale bits
  always_comb begin
    word = valid ? instr : NOP_INSTR;
  end

  assign opcode_out     = word[6:0];
  assign rd_addr_out    = word[11:7];
  assign func3_out      = word[14:12];
  assign rs1_addr_out   = word[19:15];
  assign rs2_addr_out   = word[24:20];
  assign func7_out      = word[31:25];
  assign instr_31_7_out = word[31:7];

`ifdef IMM_GEN_EN
  assign imm_out = valid ? imm_decode(instr) : 32'h0;
`endif

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction queue of DEPTH entries with head field split; IMM_GEN_EN adds imm_out.
// Latency: push at edge N is visible to decode in cycle N+1 (first-word fall-through).
// Backpressure: instr_ready_out drops when full, in reset or on flush; never depends on dec_ready_in.
module instr_fetch_queue
  import instr_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = NOP,
  localparam int         IDX_W     = $clog2(DEPTH),
  localparam int         PTR_W     = IDX_W + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             instr_valid_in,
  input  logic [31:0]      instr_in,
  input  logic [PC_W-1:0]  pc_in,
  output logic             instr_ready_out,
  output logic             dec_valid_out,
  input  logic             dec_ready_in,
  output logic [6:0]       opcode_out,
  output logic [4:0]       rd_addr_out,
  output logic [2:0]       func3_out,
  output logic [4:0]       rs1_addr_out,
  output logic [4:0]       rs2_addr_out,
  output logic [6:0]       func7_out,
  output logic [24:0]      instr_31_7_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [PTR_W-1:0] count_out
`ifdef IMM_GEN_EN
  ,
  output logic [31:0]      imm_out
`endif
);

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty, push, pop;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign empty  = (wr_ptr == rd_ptr);

  assign instr_ready_out = !rst_in && !full && !flush_in;
  assign dec_valid_out   = !empty && !flush_in;
  assign push            = instr_valid_in && instr_ready_out;
  assign pop             = dec_valid_out && dec_ready_in;
  assign count_out       = wr_ptr - rd_ptr;

  // Pointer update: reset beats flush, flush discards any push/pop of the same cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; push already excludes reset and flush cycles
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_instr[wr_idx] <= instr_in;
      mem_pc[wr_idx]    <= pc_in;
    end
  end

  assign pc_out = dec_valid_out ? mem_pc[rd_idx] : '0;

  instr_field_split #(
    .NOP_INSTR (NOP_INSTR)
  ) u_split (
    .instr          (mem_instr[rd_idx]),
    .valid          (dec_valid_out),
    .opcode_out     (opcode_out),
    .rd_addr_out    (rd_addr_out),
    .func3_out      (func3_out),
    .rs1_addr_out   (rs1_addr_out),
    .rs2_addr_out   (rs2_addr_out),
    .func7_out      (func7_out),
    .instr_31_7_out (instr_31_7_out)
`ifdef IMM_GEN_EN
    ,
    .imm_out        (imm_out)
`endif
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue against a queue-based reference model.
// Latency: model expects pushes visible the cycle after the edge.
// Backpressure: random dec_ready_in, flush and reset drive the queue through full/empty.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, instr_valid_in, dec_ready_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_ready_out, dec_valid_out;
  logic [6:0]  opcode_out, func7_out;
  logic [4:0]  rd_addr_out, rs1_addr_out, rs2_addr_out;
  logic [2:0]  func3_out;
  logic [24:0] instr_31_7_out;
  logic [31:0] pc_out;
  logic [2:0]  count_out;
`ifdef IMM_GEN_EN
  logic [31:0] imm_out;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: entries held as {pc, instr}, oldest at index 0
  logic [63:0] q[$];

  always #5 clk_in = ~clk_in;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .instr_valid_in  (instr_valid_in),
    .instr_in        (instr_in),
    .pc_in           (pc_in),
    .instr_ready_out (instr_ready_out),
    .dec_valid_out   (dec_valid_out),
    .dec_ready_in    (dec_ready_in),
    .opcode_out      (opcode_out),
    .rd_addr_out     (rd_addr_out),
    .func3_out       (func3_out),
    .rs1_addr_out    (rs1_addr_out),
    .rs2_addr_out    (rs2_addr_out),
    .func7_out       (func7_out),
    .instr_31_7_out  (instr_31_7_out),
    .pc_out          (pc_out),
    .count_out       (count_out)
`ifdef IMM_GEN_EN
    ,
    .imm_out         (imm_out)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef IMM_GEN_EN
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return {{20{i[31]}}, i[31:20]};
      7'h23:               return {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63:               return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        return {i[31:12], 12'b0};
      7'h6F:               return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:             return 32'h0;
    endcase
  endfunction
`endif

  // Compare every output against what the model's contents and current inputs dictate
  task automatic model_check();
    logic        v;
    logic [31:0] w;
    logic [31:0] p;
    v = (q.size() > 0) && !flush_in;
    w = v ? q[0][31:0]  : 32'h0000_0013;
    p = v ? q[0][63:32] : 32'h0;
    chk("ready",   instr_ready_out, !rst_in && (q.size() < DEPTH) && !flush_in);
    chk("valid",   dec_valid_out,   v);
    chk("count",   count_out,       q.size());
    chk("opcode",  opcode_out,      w[6:0]);
    chk("rd",      rd_addr_out,     w[11:7]);
    chk("func3",   func3_out,       w[14:12]);
    chk("rs1",     rs1_addr_out,    w[19:15]);
    chk("rs2",     rs2_addr_out,    w[24:20]);
    chk("func7",   func7_out,       w[31:25]);
    chk("i31_7",   instr_31_7_out,  w[31:7]);
    chk("pc",      pc_out,          p);
`ifdef IMM_GEN_EN
    chk("imm",     imm_out,         v ? ref_imm(w) : 32'h0);
`endif
  endtask

  // Advance the model with the inputs held across the edge
  task automatic model_update();
    bit do_push, do_pop;
    if (rst_in || flush_in) begin
      q.delete();
    end else begin
      do_push = instr_valid_in && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && dec_ready_in;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({pc_in, instr_in});
    end
  endtask

  task automatic drv(input bit r, input bit f, input bit v, input logic [31:0] ins,
                     input logic [31:0] p, input bit dr);
    rst_in = r; flush_in = f; instr_valid_in = v; instr_in = ins; pc_in = p; dec_ready_in = dr;
    @(negedge clk_in);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};

  initial begin
    logic [31:0] ri;
    rst_in = 1'b1; flush_in = 1'b0; instr_valid_in = 1'b0; instr_in = '0; pc_in = '0; dec_ready_in = 1'b0;
    @(posedge clk_in);
    q.delete();
    #1;

    // Reset state while reset is still asserted
    drv(1, 0, 1, 32'h1, 32'h4, 1);
    chk("rst_ready", instr_ready_out, 1'b0);
    chk("rst_valid", dec_valid_out, 1'b0);
    chk("rst_opcode", opcode_out, 7'h13);
    tick();

    // First cycle after reset: ready, push addi x1,x0,10 at 0x100
    drv(0, 0, 1, 32'h00A0_0093, 32'h100, 0);
    chk("post_rst_ready", instr_ready_out, 1'b1);
    chk("empty_pc", pc_out, 32'h0);
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 0);
    chk("addi_valid", dec_valid_out, 1'b1);
    chk("addi_opcode", opcode_out, 7'h13);
    chk("addi_rd", rd_addr_out, 5'd1);
    chk("addi_rs1", rs1_addr_out, 5'd0);
    chk("addi_func3", func3_out, 3'd0);
    chk("addi_pc", pc_out, 32'h100);
`ifdef IMM_GEN_EN
    chk("addi_imm", imm_out, 32'd10);
`endif
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    tick();

    // Fill to DEPTH with decode stalled; a fifth offer must be refused
    for (int i = 0; i < DEPTH; i++) begin
      drv(0, 0, 1, 32'h0010_0093 + (i << 7), 32'h200 + 4 * i, 0);
      tick();
    end
    drv(0, 0, 1, 32'hDEAD_B0B3, 32'h300, 0);
    chk("full_count", count_out, 3'd4);
    chk("full_ready", instr_ready_out, 1'b0);
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 0);
    chk("after_pop_ready", instr_ready_out, 1'b1);
    chk("after_pop_count", count_out, 3'd3);
    chk("after_pop_pc", pc_out, 32'h204);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 32'h0, 32'h0, 1);
      tick();
    end

    // Sustained push+pop: occupancy pinned at 1 while pointers wrap
    drv(0, 0, 1, 32'h0000_0513, 32'h400, 1);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drv(0, 0, 1, 32'h0000_0513 + (i << 20), 32'h400 + 4 * i, 1);
      chk("stream_count", count_out, 3'd1);
      chk("stream_pc", pc_out, 32'h400 + 4 * (i - 1));
      tick();
    end
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    tick();

    // Flush with three entries queued and a concurrent offer
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 32'h0020_0113, 32'h500 + 4 * i, 0);
      tick();
    end
    drv(0, 1, 1, 32'h0030_0193, 32'h600, 1);
    chk("flush_valid", dec_valid_out, 1'b0);
    chk("flush_opcode", opcode_out, 7'h13);
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 0);
    chk("post_flush_count", count_out, 3'd0);
    chk("post_flush_valid", dec_valid_out, 1'b0);
    chk("post_flush_pc", pc_out, 32'h0);
    tick();

`ifdef IMM_GEN_EN
    drv(0, 0, 1, 32'hFE00_0EE3, 32'h700, 0);
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    chk("beq_imm", imm_out, 32'hFFFF_FFFC);
    tick();
    drv(0, 0, 1, 32'h1234_52B7, 32'h704, 0);
    tick();
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    chk("lui_imm", imm_out, 32'h1234_5000);
    tick();
`endif

    // Randomized traffic including occasional flush and mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      ri = {$urandom(), 7'h0} | {25'h0, ops[$urandom_range(0, 8)]};
      drv($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
          ri, $urandom(), $urandom_range(0, 2) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
